reg_file_sync: RTL and testbench
================================

Name: reg_file_sync

Overview:
- Synchronous-write, asynchronous-read register file for the asynchronous processor datapath.
- Holds 16 general registers (R0–R14, with R15 acting as the PC) plus a separate CPSR status register (ports spelled "cspr").
- Has three write ports for concurrent result writeback and four combinational read ports feeding the ALU/multiplier operand buses.

Parameters:
DATA_W, 32, width of every register and data port
ADDR_W, 4, register address width (2^ADDR_W = 16 registers)
PC_IDX, 15, register index aliased as program counter
PC_RESET, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  system clock, all writes on rising edge
rst  in  1  asynchronous active-high reset
in_address_1..4  in  4 each  read addresses for ports 1–4
out_data_1..4  out  32 each  read data for ports 1–4
write_address_1..3  in  4 each  write addresses for ports 1–3
write_data_1..3  in  32 each  write data for ports 1–3
write_enable_1..3  in  1 each  write strobes for ports 1–3
pc_update  in  32  new PC value
pc_write  in  1  PC write strobe
cspr_update  in  32  new CPSR value
cspr_write  in  1  CPSR write strobe
pc  out  32  current R15 contents
cspr  out  32  current CPSR contents

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset while rst=1, independent of clk:
  - R0–R14 = 0, R15 = PC_RESET, CPSR = 0.
  - All writes ignored.
  - Outputs reflect reset values combinationally.
  - Reset asserted mid-cycle discards any pending write.
- Reads:
  - out_data_n = R[in_address_n], purely combinational, zero latency.
  - No write-to-read bypass: a value written at edge k becomes visible on reads immediately after edge k, not before.
  - Reading address 15 returns the PC.
- Writes, on the rising clk edge when rst=0:
  - Each port with write_enable_n=1 stores write_data_n into R[write_address_n].
  - Enables are level-sensitive; a held enable rewrites the register every cycle.
  - Enable X/undriven is treated as 0. Unconnected cspr_write and pc_write therefore never write.
- Same-address conflicts in one cycle: priority is port 3 > port 2 > port 1. Only the highest-priority enabled port lands.
- PC:
  - pc_write=1 loads pc_update into R15 and overrides any general-port write to address 15 in the same cycle.
  - Otherwise R15 is writable through the ports like any other register.
  - No auto-increment inside this block.
- CPSR: cspr_write=1 loads cspr_update on the rising edge; otherwise it holds. It is not addressable through the read/write ports.
- Full 32-bit values are stored with no sign or width transformation.
- The multiplier is a separate combinational block and is out of scope here.

Test Plan:
- Reset: assert rst mid-cycle → all out_data = 0, pc = 0, cspr = 0 immediately, with no clk edge needed. Release rst; a write with enable_1=1 on the next edge lands.
- Basic write/read: port1 writes R0=32'h2 and port2 writes R1=32'h2 on one edge; set in_address_1=0 and in_address_2=1 → out_data_1 = out_data_2 = 32'h2 after that edge. Before that edge both read 0.
- Iterative writeback: hold write_enable_3=1 with write_address_3=2, feeding write_data_3 = out_data_3 × out_data_1 (external multiply, R2 seeded to 2) for 10 edges → R2 goes 2, 4, 8, … 32'h800 (2^11). in_address_3=2 tracks each value one edge late.
- Conflict: ports 1, 2 and 3 all write R5 with 11, 22, 33 on the same edge → R5 = 33. Drop port 3 → next edge R5 = 22.
- PC: pc_write=1, pc_update=32'h100, plus port1 writing R15=32'hDEAD on the same edge → pc = 32'h100 and out_data_4 (addr 15) = 32'h100. Next edge with only port1 writing R15=32'h40 → pc = 32'h40.
- CPSR: cspr_write=1, cspr_update=32'hF000_0000 → cspr updates on that edge. With cspr_write=0 and cspr_update changing, cspr is unchanged.

Source files
------------

// File: rtl/reg_file_sync.sv
// Register file: 16 x DATA_W general registers (R15 doubles as PC) plus CPSR.
// Three synchronous write ports, four combinational read ports.
module reg_file_sync #(
   parameter int                  DATA_W   = 32,
   parameter int                  ADDR_W   = 4,
   parameter int                  PC_IDX   = 15,
   parameter logic [DATA_W-1:0]   PC_RESET = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] in_address_1,
   input  logic [ADDR_W-1:0] in_address_2,
   input  logic [ADDR_W-1:0] in_address_3,
   input  logic [ADDR_W-1:0] in_address_4,
   output logic [DATA_W-1:0] out_data_1,
   output logic [DATA_W-1:0] out_data_2,
   output logic [DATA_W-1:0] out_data_3,
   output logic [DATA_W-1:0] out_data_4,
   input  logic [ADDR_W-1:0] write_address_1,
   input  logic [ADDR_W-1:0] write_address_2,
   input  logic [ADDR_W-1:0] write_address_3,
   input  logic [DATA_W-1:0] write_data_1,
   input  logic [DATA_W-1:0] write_data_2,
   input  logic [DATA_W-1:0] write_data_3,
   input  logic              write_enable_1,
   input  logic              write_enable_2,
   input  logic              write_enable_3,
   input  logic [DATA_W-1:0] pc_update,
   input  logic              pc_write,
   input  logic [DATA_W-1:0] cspr_update,
   input  logic              cspr_write,
   output logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] cspr
);

   localparam int NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] regs     [NREG];
   logic [DATA_W-1:0] regs_nxt [NREG];
   logic [DATA_W-1:0] cspr_q;

   // Later assignments win: port 3 > port 2 > port 1, then pc_write on R15.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_nxt[i] = regs[i];
         if (write_enable_1 && write_address_1 == ADDR_W'(i))
            regs_nxt[i] = write_data_1;
         if (write_enable_2 && write_address_2 == ADDR_W'(i))
            regs_nxt[i] = write_data_2;
         if (write_enable_3 && write_address_3 == ADDR_W'(i))
            regs_nxt[i] = write_data_3;
         if (pc_write && i == PC_IDX)
            regs_nxt[i] = pc_update;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= (i == PC_IDX) ? PC_RESET : '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= regs_nxt[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cspr_q <= '0;
      end else if (cspr_write) begin
         cspr_q <= cspr_update;
      end
   end

   assign out_data_1 = regs[in_address_1];
   assign out_data_2 = regs[in_address_2];
   assign out_data_3 = regs[in_address_3];
   assign out_data_4 = regs[in_address_4];
   assign pc         = regs[PC_IDX];
   assign cspr       = cspr_q;

endmodule

// File: tb/tb_reg_file_sync.sv
// Bench for reg_file_sync: directed scenarios plus randomized traffic
// checked against an array model of the register file.
module tb_reg_file_sync;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  in_address_1, in_address_2, in_address_3, in_address_4;
   logic [31:0] out_data_1, out_data_2, out_data_3, out_data_4;
   logic [3:0]  write_address_1, write_address_2, write_address_3;
   logic [31:0] write_data_1, write_data_2, write_data_3;
   logic        write_enable_1, write_enable_2, write_enable_3;
   logic [31:0] pc_update, cspr_update, pc, cspr;
   logic        pc_write, cspr_write;

   logic [31:0] m [16];
   logic [31:0] mc;
   int          n_cmp = 0;
   int          n_err = 0;

   reg_file_sync dut (
      .clk(clk), .rst(rst),
      .in_address_1(in_address_1), .in_address_2(in_address_2),
      .in_address_3(in_address_3), .in_address_4(in_address_4),
      .out_data_1(out_data_1), .out_data_2(out_data_2),
      .out_data_3(out_data_3), .out_data_4(out_data_4),
      .write_address_1(write_address_1), .write_address_2(write_address_2),
      .write_address_3(write_address_3),
      .write_data_1(write_data_1), .write_data_2(write_data_2),
      .write_data_3(write_data_3),
      .write_enable_1(write_enable_1), .write_enable_2(write_enable_2),
      .write_enable_3(write_enable_3),
      .pc_update(pc_update), .pc_write(pc_write),
      .cspr_update(cspr_update), .cspr_write(cspr_write),
      .pc(pc), .cspr(cspr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      write_enable_1 = 0; write_enable_2 = 0; write_enable_3 = 0;
      pc_write = 0; cspr_write = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m[i] = '0;
      mc = '0;
   endtask

   // Architectural effect of one rising edge: the highest-priority
   // enabled writer of each register wins, pc_write beats all for R15.
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         if (write_enable_1) m[write_address_1] = write_data_1;
         if (write_enable_2) m[write_address_2] = write_data_2;
         if (write_enable_3) m[write_address_3] = write_data_3;
         if (pc_write) m[15] = pc_update;
         if (cspr_write) mc = cspr_update;
      end
      #1;
   endtask

   task automatic check_rand_reads(input string tag);
      in_address_1 = 4'($urandom_range(0, 15));
      in_address_2 = 4'($urandom_range(0, 15));
      in_address_3 = 4'($urandom_range(0, 15));
      in_address_4 = 4'($urandom_range(0, 15));
      #1;
      chk({tag, "_rd1"}, out_data_1, m[in_address_1]);
      chk({tag, "_rd2"}, out_data_2, m[in_address_2]);
      chk({tag, "_rd3"}, out_data_3, m[in_address_3]);
      chk({tag, "_rd4"}, out_data_4, m[in_address_4]);
      chk({tag, "_pc"}, pc, m[15]);
      chk({tag, "_cspr"}, cspr, mc);
   endtask

   task automatic sweep(input string tag);
      for (int a = 0; a < 16; a += 4) begin
         in_address_1 = 4'(a);
         in_address_2 = 4'(a + 1);
         in_address_3 = 4'(a + 2);
         in_address_4 = 4'(a + 3);
         #1;
         chk({tag, "_p1"}, out_data_1, m[a]);
         chk({tag, "_p2"}, out_data_2, m[a + 1]);
         chk({tag, "_p3"}, out_data_3, m[a + 2]);
         chk({tag, "_p4"}, out_data_4, m[a + 3]);
      end
      chk({tag, "_pc"}, pc, m[15]);
      chk({tag, "_cspr"}, cspr, mc);
   endtask

   initial begin
      rst = 1;
      idle();
      write_address_1 = 0; write_address_2 = 0; write_address_3 = 0;
      write_data_1 = 0; write_data_2 = 0; write_data_3 = 0;
      pc_update = 0; cspr_update = 0;
      in_address_1 = 0; in_address_2 = 0; in_address_3 = 0; in_address_4 = 0;
      model_reset();
      #12;
      sweep("reset");
      rst = 0;
      tick();

      // basic write/read
      write_enable_1 = 1; write_address_1 = 0; write_data_1 = 32'h2;
      write_enable_2 = 1; write_address_2 = 1; write_data_2 = 32'h2;
      in_address_1 = 0; in_address_2 = 1;
      #1;
      chk("basic_pre1", out_data_1, 32'h0);
      chk("basic_pre2", out_data_2, 32'h0);
      tick();
      idle();
      chk("basic_r0", out_data_1, 32'h2);
      chk("basic_r1", out_data_2, 32'h2);

      // iterative writeback through an external multiply
      write_enable_3 = 1; write_address_3 = 2; write_data_3 = 32'h2;
      tick();
      in_address_1 = 0; in_address_3 = 2;
      #1;
      chk("iter_seed", out_data_3, 32'h2);
      for (int k = 1; k <= 10; k++) begin
         write_data_3 = out_data_3 * out_data_1;
         tick();
         chk($sformatf("iter_%0d", k), out_data_3, 32'h1 << (k + 1));
      end
      idle();
      chk("iter_final", out_data_3, 32'h800);

      // same-address conflict
      write_enable_1 = 1; write_address_1 = 5; write_data_1 = 11;
      write_enable_2 = 1; write_address_2 = 5; write_data_2 = 22;
      write_enable_3 = 1; write_address_3 = 5; write_data_3 = 33;
      in_address_4 = 5;
      tick();
      chk("conf_p3", out_data_4, 32'd33);
      write_enable_3 = 0;
      tick();
      chk("conf_p2", out_data_4, 32'd22);
      idle();

      // PC override and general-port PC write
      pc_write = 1; pc_update = 32'h100;
      write_enable_1 = 1; write_address_1 = 15; write_data_1 = 32'hDEAD;
      in_address_4 = 15;
      tick();
      chk("pc_ovr", pc, 32'h100);
      chk("pc_ovr_rd", out_data_4, 32'h100);
      pc_write = 0; write_data_1 = 32'h40;
      tick();
      chk("pc_port", pc, 32'h40);
      idle();

      // CPSR load and hold
      cspr_write = 1; cspr_update = 32'hF000_0000;
      tick();
      chk("cspr_ld", cspr, 32'hF000_0000);
      cspr_write = 0; cspr_update = 32'h1234_5678;
      tick();
      chk("cspr_hold", cspr, 32'hF000_0000);

      // asynchronous reset mid-cycle, pending writes discarded
      sweep("pre_rst");
      #2;
      write_enable_1 = 1; write_address_1 = 7; write_data_1 = 32'hCAFE;
      pc_write = 1; pc_update = 32'h55; cspr_write = 1;
      rst = 1;
      model_reset();
      #1;
      sweep("async_rst");
      tick();
      sweep("rst_edge");
      #2;
      rst = 0;
      idle();
      write_enable_1 = 1; write_address_1 = 7; write_data_1 = 32'hBEEF;
      in_address_1 = 7;
      tick();
      idle();
      chk("post_rst_wr", out_data_1, 32'hBEEF);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         write_enable_1 = 1'($urandom);
         write_enable_2 = 1'($urandom);
         write_enable_3 = 1'($urandom);
         write_address_1 = 4'($urandom);
         write_address_2 = ($urandom_range(0, 3) == 0) ? write_address_1
                           : 4'($urandom);
         write_address_3 = ($urandom_range(0, 3) == 0) ? write_address_2
                           : 4'($urandom);
         write_data_1 = $urandom;
         write_data_2 = $urandom;
         write_data_3 = $urandom;
         pc_write = ($urandom_range(0, 7) == 0);
         pc_update = $urandom;
         cspr_write = 1'($urandom);
         cspr_update = $urandom;
         if ($urandom_range(0, 99) == 0) begin
            #2;
            rst = 1;
            model_reset();
            #1;
            chk("rnd_rst_pc", pc, 32'h0);
            #1;
            rst = 0;
         end
         tick();
         check_rand_reads("rnd");
      end
      idle();
      tick();
      sweep("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
